// File: rtl/uart_pkg.sv
// Shared types and constants for the UART key receiver.
// PARITY_EN: when defined, the FSM gains a PARITY state (even parity).
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_BREAK
   } uart_state_e;

   localparam logic [7:0] KEY_W      = 8'h57;
   localparam logic [7:0] KEY_A      = 8'h41;
   localparam logic [7:0] KEY_S      = 8'h53;
   localparam logic [7:0] KEY_D      = 8'h44;
   localparam logic [7:0] KEY_LC_OFS = 8'h20;

   localparam int unsigned DIR_W    = 0;
   localparam int unsigned DIR_A    = 1;
   localparam int unsigned DIR_S    = 2;
   localparam int unsigned DIR_D    = 3;
   localparam int unsigned DIR_BITS = 4;

   // Map a received key to a one-hot direction; unknown codes keep the current one.
   function automatic logic [DIR_BITS-1:0] key_decode(input logic [7:0] code,
                                                       input logic [DIR_BITS-1:0] cur);
      logic [DIR_BITS-1:0] d;
      d = cur;
      case (code)
         KEY_W, KEY_W + KEY_LC_OFS: begin d = '0; d[DIR_W] = 1'b1; end
         KEY_A, KEY_A + KEY_LC_OFS: begin d = '0; d[DIR_A] = 1'b1; end
         KEY_S, KEY_S + KEY_LC_OFS: begin d = '0; d[DIR_S] = 1'b1; end
         KEY_D, KEY_D + KEY_LC_OFS: begin d = '0; d[DIR_D] = 1'b1; end
         default: d = cur;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/uart_key_rx_if.sv
// Receiver-side bundle: serial input plus decoded payload, pulses and status.
interface uart_key_rx_if
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8
);
   logic                 rx;
   logic [DATA_BITS-1:0] data;
   logic                 data_valid;
   logic                 frame_err;
   logic                 parity_err;
   logic [DIR_BITS-1:0]  dir;
   logic                 busy;

   modport master (input rx, output data, data_valid, frame_err, parity_err, dir, busy);
   modport slave  (output rx, input data, data_valid, frame_err, parity_err, dir, busy);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every CLK_HZ/(BAUD*OVERSAMPLE) clocks.
module uart_baud_tick #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic clk_50M,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);
   localparam int unsigned DIV = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // Divider counter; clr holds it at zero so each frame starts on a fresh period.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == CNT_LAST) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + 1'b1;
         tick <= 1'b0;
      end
   end
endmodule

// File: rtl/uart_key_rx.sv
// Oversampled UART receiver with glitch rejection, framing check and WASD decoder.
// PARITY_EN: when defined, an even-parity bit precedes the stop bit and parity_err is live.
module uart_key_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8
) (
   input  logic           clk_50M,
   input  logic           rst_n,
   uart_key_rx_if.master  bus
);
   localparam int unsigned TCW = $clog2(OVERSAMPLE);
   localparam int unsigned BCW = $clog2(DATA_BITS);
   localparam logic [TCW-1:0] HALF_LAST = TCW'(OVERSAMPLE / 2 - 1);
   localparam logic [TCW-1:0] FULL_LAST = TCW'(OVERSAMPLE - 1);
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);
`ifdef PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic [1:0]           rx_sync;
   logic                 rxs;
   uart_state_e          state, state_nxt;
   logic [TCW-1:0]       tcnt, tcnt_nxt;
   logic [BCW-1:0]       bcnt, bcnt_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt, data_q, data_nxt;
   logic                 par_q, par_nxt, par_bad;
   logic                 dv_q, dv_nxt, fe_q, fe_nxt, pe_q, pe_nxt, busy_q;
   logic [DIR_BITS-1:0]  dir_q, dir_nxt;
   logic                 tick, tick_clr;

   // Two-flop synchroniser, idles high.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) rx_sync <= 2'b11;
      else        rx_sync <= {rx_sync[0], bus.rx};
   end
   assign rxs = rx_sync[1];

   assign tick_clr = (state == ST_IDLE);
   assign par_bad  = PAR_EN & par_q;

   uart_baud_tick #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_tick (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .clr     (tick_clr),
      .tick    (tick)
   );

   // Next-state, shift/parity accumulation, result pulses and key decode.
   always_comb begin
      state_nxt = state;
      tcnt_nxt  = tcnt;
      bcnt_nxt  = bcnt;
      shreg_nxt = shreg;
      par_nxt   = par_q;
      data_nxt  = data_q;
      dv_nxt    = 1'b0;
      fe_nxt    = 1'b0;
      pe_nxt    = 1'b0;
      dir_nxt   = dir_q;
      if (dv_q) dir_nxt = key_decode(8'(data_q), dir_q);

      unique case (state)
         ST_IDLE: begin
            tcnt_nxt = '0;
            bcnt_nxt = '0;
            par_nxt  = 1'b0;
            if (!rxs) state_nxt = ST_START;
         end
         ST_START: if (tick) begin
            if (tcnt == HALF_LAST) begin
               tcnt_nxt  = '0;
               state_nxt = rxs ? ST_IDLE : ST_DATA;
            end else begin
               tcnt_nxt = tcnt + 1'b1;
            end
         end
         ST_DATA: if (tick) begin
            if (tcnt == FULL_LAST) begin
               tcnt_nxt  = '0;
               shreg_nxt = {rxs, shreg[DATA_BITS-1:1]};
               par_nxt   = par_q ^ rxs;
               bcnt_nxt  = bcnt + 1'b1;
               if (bcnt == BIT_LAST) begin
`ifdef PARITY_EN
                  state_nxt = ST_PARITY;
`else
                  state_nxt = ST_STOP;
`endif
               end
            end else begin
               tcnt_nxt = tcnt + 1'b1;
            end
         end
`ifdef PARITY_EN
         ST_PARITY: if (tick) begin
            if (tcnt == FULL_LAST) begin
               tcnt_nxt  = '0;
               par_nxt   = par_q ^ rxs;
               state_nxt = ST_STOP;
            end else begin
               tcnt_nxt = tcnt + 1'b1;
            end
         end
`endif
         ST_STOP: if (tick) begin
            if (tcnt == FULL_LAST) begin
               tcnt_nxt = '0;
               if (!rxs) begin
                  fe_nxt    = 1'b1;
                  state_nxt = ST_BREAK;
               end else begin
                  state_nxt = ST_IDLE;
                  if (par_bad) begin
                     pe_nxt = 1'b1;
                  end else begin
                     data_nxt = shreg;
                     dv_nxt   = 1'b1;
                  end
               end
            end else begin
               tcnt_nxt = tcnt + 1'b1;
            end
         end
         ST_BREAK: if (rxs) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         tcnt   <= '0;
         bcnt   <= '0;
         shreg  <= '0;
         par_q  <= 1'b0;
         data_q <= '0;
         dv_q   <= 1'b0;
         fe_q   <= 1'b0;
         pe_q   <= 1'b0;
         dir_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         tcnt   <= tcnt_nxt;
         bcnt   <= bcnt_nxt;
         shreg  <= shreg_nxt;
         par_q  <= par_nxt;
         data_q <= data_nxt;
         dv_q   <= dv_nxt;
         fe_q   <= fe_nxt;
         pe_q   <= pe_nxt;
         dir_q  <= dir_nxt;
         busy_q <= (state_nxt != ST_IDLE);
      end
   end

   assign bus.data       = data_q;
   assign bus.data_valid = dv_q;
   assign bus.frame_err  = fe_q;
   assign bus.parity_err = pe_q;
   assign bus.dir        = dir_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_uart_key_rx.sv
// Randomised bench for uart_key_rx against an ASCII-level frame/key model.
// Build with +define+PARITY_EN to exercise the parity variant.
module tb_uart_key_rx;
   localparam int unsigned CLK_HZ = 50_000_000;
   localparam int unsigned BAUD   = 781_250;
   localparam int unsigned OVS    = 16;
   localparam int unsigned DBITS  = 8;
   localparam int unsigned DIV    = CLK_HZ / (BAUD * OVS);
   localparam int unsigned BIT    = DIV * OVS;
`ifdef PARITY_EN
   localparam int unsigned PBITS = 1;
`else
   localparam int unsigned PBITS = 0;
`endif
   localparam int unsigned LAT_LO = (DBITS + 1 + PBITS) * BIT + BIT / 2 + 1;
   localparam int unsigned LAT_HI = LAT_LO + DIV + 3;

   logic        clk_50M = 1'b0;
   logic        rst_n   = 1'b0;
   int unsigned cyc     = 0;
   int          n_chk   = 0;
   int          n_err   = 0;

   int          n_dv = 0, n_fe = 0, n_pe = 0, n_busy_rise = 0;
   int unsigned dv_cyc = 0;
   logic        dv_prev = 1'b0, busy_prev = 1'b0;
   logic [7:0]  exp_data = 8'h00;
   logic [3:0]  exp_dir  = 4'b0000;
   logic [7:0]  keys [4] = '{8'h57, 8'h41, 8'h53, 8'h44};

   uart_key_rx_if #(.DATA_BITS(DBITS)) bus();

   uart_key_rx #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVS),
      .DATA_BITS  (DBITS)
   ) dut (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #10 clk_50M = ~clk_50M;
   always @(posedge clk_50M) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference key model: fold lower-case letters to upper case, then pick a direction.
   function automatic logic [3:0] ref_dir(input logic [7:0] b, input logic [3:0] cur);
      logic [7:0] u;
      u = (b >= 8'h61 && b <= 8'h7a) ? b - 8'h20 : b;
      case (u)
         8'h57:   return 4'b0001;
         8'h41:   return 4'b0010;
         8'h53:   return 4'b0100;
         8'h44:   return 4'b1000;
         default: return cur;
      endcase
   endfunction

   // Pulse monitor: counts result pulses, checks payload on data_valid and dir one clock later.
   always @(negedge clk_50M) begin
      if (rst_n) begin
         if (bus.data_valid) begin
            n_dv++;
            dv_cyc = cyc;
            chk("dv_data", 32'(bus.data), 32'(exp_data));
            chk("dv_width", 32'(dv_prev), 32'd0);
         end
         if (dv_prev) chk("dir_after_dv", 32'(bus.dir), 32'(exp_dir));
         if (bus.frame_err)  n_fe++;
         if (bus.parity_err) n_pe++;
         if (bus.data_valid || bus.frame_err || bus.parity_err)
            chk("pulse_excl", 32'(bus.data_valid) + 32'(bus.frame_err) + 32'(bus.parity_err), 32'd1);
         if (bus.busy && !busy_prev) n_busy_rise++;
      end
      dv_prev   = bus.data_valid;
      busy_prev = bus.busy;
   end

   task automatic drive_bit(input logic b);
      bus.rx = b;
      repeat (BIT) @(negedge clk_50M);
   endtask

   // One frame; the line is left at the stop-bit level afterwards.
   task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic par_ok);
      int          dv0, fe0, pe0;
      int unsigned t0, lat;
      logic        pok, good;
      dv0 = n_dv; fe0 = n_fe; pe0 = n_pe;
`ifdef PARITY_EN
      pok = par_ok;
`else
      pok = 1'b1;
`endif
      good = stop_ok && pok;
      if (good) begin
         exp_data = b;
         exp_dir  = ref_dir(b, exp_dir);
      end
      t0 = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < int'(DBITS); i++) drive_bit(b[i]);
`ifdef PARITY_EN
      drive_bit(pok ? ^b : ~(^b));
`endif
      drive_bit(stop_ok);
      chk("n_dv",     32'(n_dv - dv0), 32'(good));
      chk("n_fe",     32'(n_fe - fe0), 32'(!stop_ok));
      chk("n_pe",     32'(n_pe - pe0), 32'(stop_ok && !pok));
      chk("data",     32'(bus.data),   32'(exp_data));
      chk("dir",      32'(bus.dir),    32'(exp_dir));
      chk("busy_end", 32'(bus.busy),   32'(!stop_ok));
      if (good) begin
         lat = dv_cyc - t0;
         chk("dv_latency", 32'(lat >= LAT_LO && lat <= LAT_HI), 32'd1);
      end
   endtask

   initial begin
      int          dv0, fe0, br0, gap;
      logic [7:0]  b;
      logic        s_ok, p_ok;
      logic [7:0]  k57;

      bus.rx = 1'b1;
      rst_n  = 1'b0;
      repeat (3) @(negedge clk_50M);
      chk("rst_data", 32'(bus.data),       32'd0);
      chk("rst_dv",   32'(bus.data_valid), 32'd0);
      chk("rst_fe",   32'(bus.frame_err),  32'd0);
      chk("rst_pe",   32'(bus.parity_err), 32'd0);
      chk("rst_dir",  32'(bus.dir),        32'd0);
      chk("rst_busy", 32'(bus.busy),       32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_50M);

      // Single good key.
      send_frame(8'h41, 1'b1, 1'b1);
      drive_bit(1'b1);

      // Back-to-back frames, single stop bit.
      send_frame(8'h64, 1'b1, 1'b1);
      send_frame(8'h57, 1'b1, 1'b1);
      drive_bit(1'b1);

      // Framing error, line held low, then recovery.
      send_frame(8'h53, 1'b0, 1'b1);
      drive_bit(1'b0);
      drive_bit(1'b0);
      chk("break_hold", 32'(bus.busy), 32'd1);
      drive_bit(1'b1);
      chk("break_exit", 32'(bus.busy), 32'd0);
      send_frame(8'h41, 1'b1, 1'b1);
      drive_bit(1'b1);

      // Short start glitch of three ticks.
      dv0 = n_dv; fe0 = n_fe; br0 = n_busy_rise;
      bus.rx = 1'b0;
      repeat (3 * DIV) @(negedge clk_50M);
      drive_bit(1'b1);
      drive_bit(1'b1);
      chk("glitch_busy", 32'(n_busy_rise - br0), 32'd1);
      chk("glitch_dv",   32'(n_dv - dv0),        32'd0);
      chk("glitch_fe",   32'(n_fe - fe0),        32'd0);
      chk("glitch_data", 32'(bus.data),          32'(exp_data));
      chk("glitch_idle", 32'(bus.busy),          32'd0);

`ifdef PARITY_EN
      send_frame(8'h44, 1'b1, 1'b0);
      drive_bit(1'b1);
      send_frame(8'h44, 1'b1, 1'b1);
      drive_bit(1'b1);
`endif

      // Reset during the data bits of 0x57.
      k57 = 8'h57;
      dv0 = n_dv;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(k57[i]);
      repeat (5) @(negedge clk_50M);
      rst_n = 1'b0;
      #1;
      exp_data = 8'h00;
      exp_dir  = 4'b0000;
      chk("mid_rst_data", 32'(bus.data),       32'd0);
      chk("mid_rst_dir",  32'(bus.dir),        32'd0);
      chk("mid_rst_busy", 32'(bus.busy),       32'd0);
      chk("mid_rst_dv",   32'(bus.data_valid), 32'd0);
      bus.rx = 1'b1;
      repeat (BIT) @(negedge clk_50M);
      rst_n = 1'b1;
      repeat (BIT) @(negedge clk_50M);
      chk("mid_rst_nodv", 32'(n_dv - dv0), 32'd0);
      send_frame(8'h61, 1'b1, 1'b1);
      chk("after_rst_dir", 32'(bus.dir), 32'b0010);
      drive_bit(1'b1);

      // Random keys, case, junk codes, stop/parity errors and idle gaps.
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 3) != 0) begin
            b = keys[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 1) b = b + 8'h20;
         end else begin
            b = 8'($urandom);
         end
         s_ok = ($urandom_range(0, 5) != 0);
         p_ok = ($urandom_range(0, 4) != 0);
         send_frame(b, s_ok, p_ok);
         if (!s_ok) drive_bit(1'b1);
         gap = $urandom_range(0, 2);
         repeat (gap * int'(BIT) / 2) @(negedge clk_50M);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/uart_key_rx.md
# uart_key_rx

Parametrised UART receiver with oversampled mid-bit sampling, start-glitch rejection and framing-error detection, plus a WASD command decoder driving one-hot direction outputs. Sits between the board RX pin and the motion/LED logic on the 50 MHz domain. Replaces the fixed-rate receiver. Accepts upper- and lower-case keys and holds the last valid command.

## Interface
- CLK_HZ, 50_000_000: input clock frequency.
- BAUD, 9600: line rate.
- OVERSAMPLE, 16: ticks per bit. Must be an even number ≥ 4.
- DATA_BITS, 8: payload bits, LSB first, range 5–8.
- clk_50M  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- rx  in  1  asynchronous serial input; idle high.
- data  out  DATA_BITS  last received payload; updates only on a good frame.
- data_valid  out  1  one-cycle pulse when data updates.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- parity_err  out  1  one-cycle pulse on parity mismatch. Constant 0 without PARITY_EN.
- dir  out  4  one-hot held command: [0]=W, [1]=A, [2]=S, [3]=D.
- busy  out  1  high in any state other than IDLE.

## Operation
- rx passes through a 2-flop synchroniser; all logic uses the synchronised value rxs.
- The baud tick pulses for 1 clk every DIV = CLK_HZ/(BAUD*OVERSAMPLE) cycles, using integer division (325 at the defaults). The tick counter restarts when the FSM leaves IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: when rxs is 0 → START, and the tick counter clears.
- START: after OVERSAMPLE/2 ticks, re-sample rxs. If rxs=1 → IDLE (glitch rejected, no pulse). If rxs=0 → DATA.
- DATA: sample every OVERSAMPLE ticks and shift bits in LSB first. After DATA_BITS samples → PARITY if PARITY_EN is defined, otherwise STOP.
- PARITY: sample after OVERSAMPLE ticks, then → STOP.
- STOP: sample after OVERSAMPLE ticks.
  - rxs=1 with no parity error: load data and pulse data_valid, then → IDLE.
  - rxs=1 with a parity error: pulse parity_err, leave data unchanged, then → IDLE.
  - rxs=0: pulse frame_err, then → BREAK.
- BREAK: wait for rxs=1, then → IDLE. This prevents a held-low line from retriggering.
- Key decoder: on data_valid, map the payload to dir.
  - 0x57/0x77 → 0001
  - 0x41/0x61 → 0010
  - 0x53/0x73 → 0100
  - 0x44/0x64 → 1000
  - Any other code leaves dir unchanged.
- When DATA_BITS < 8, the payload is zero-extended before decode.

## Timing
- Reset values: data=0, data_valid=0, frame_err=0, parity_err=0, dir=0000, busy=0, FSM in IDLE, synchroniser flops=1.
- rx-to-FSM latency: 2 clk (synchroniser) plus 1 clk (edge registration).
- data_valid, frame_err and parity_err assert 1 clk after the STOP-sample tick. They are mutually exclusive and last exactly 1 clk.
- dir updates 1 clk after data_valid.
- busy rises 1 clk after the synchronised falling edge and falls in the cycle the FSM returns to IDLE.
- Reset mid-frame aborts immediately: all outputs return to reset values, and the partial frame is discarded with no pulses.
- A new start edge in the same cycle as the return to IDLE is detected on the next clk. Back-to-back frames with a single stop bit must be received.

## Configuration
- PARITY_EN: when defined, the receiver expects an even-parity bit between the data bits and the stop bit, the PARITY state exists, and parity_err is live.
- Without PARITY_EN: the frame is 8N1-style, the PARITY state is compiled out, and parity_err is tied to 0.

## Structure
- Package uart_pkg holds:
  - the FSM state enum;
  - KEY_W, KEY_A, KEY_S, KEY_D (upper case) with a 0x20 lower-case offset constant;
  - DIR_W/A/S/D bit-index constants.
- Sub-module uart_baud_tick, with parameters CLK_HZ, BAUD, OVERSAMPLE and ports clk_50M, rst_n, clr, tick.
- FSM, shift register and decoder are in the top-level module.

## Test plan
- Send 0x41 at 9600 8N1: expect data=0x41, a single data_valid pulse, then dir=0010 one clk later, and no error pulses.
- Send 0x64 followed immediately by 0x57, with no idle gap: expect two data_valid pulses, dir=1000 then dir=0001.
- Send 0x53 with the stop bit forced to 0, then hold rx low for 2 bit times, then send 0x41: expect frame_err, data and dir unchanged after the bad frame, BREAK held until rx rises, then 0x41 received.
- Drive a 3-tick low glitch on idle rx: expect busy to pulse, no data_valid, no frame_err, data unchanged.
- With PARITY_EN defined, send 0x44 with odd parity: expect parity_err, no data_valid, dir unchanged. Then send 0x44 with correct parity: expect dir=1000.
- Assert rst_n low in the middle of the DATA state of 0x57: expect all outputs reset within that cycle. After release, the next frame 0x61 gives dir=0010.
